// File: rtl/tiny_exec_pkg.sv
// Shared constants, opcodes and types for the tiny tensor-core execution datapath.
// Pure declarations: no latency and no flow control.
package tiny_exec_pkg;

    localparam int DATA_W = 4;
    localparam int DIM    = 4;
    localparam int NREGS  = 8;

    localparam logic [7:0] ADD      = 8'h00;
    localparam logic [7:0] SUB      = 8'h01;
    localparam logic [7:0] MUL      = 8'h02;
    localparam logic [7:0] EQL      = 8'h03;
    localparam logic [7:0] GRT      = 8'h04;
    localparam logic [7:0] ADD_IMM  = 8'h09;
    localparam logic [7:0] SUB_IMM  = 8'h0A;
    localparam logic [7:0] MOVE_CPU = 8'h0B;
    localparam logic [7:0] RESET    = 8'h0D;

    typedef logic signed [DATA_W-1:0] data_t;

    typedef enum logic [1:0] {
        ST_COMPUTE = 2'd0,
        ST_DONE    = 2'd1,
        ST_HOLD    = 2'd2
    } mma_state_t;

endpackage

// File: rtl/tiny_exec_dot4.sv
// Four-term signed dot product, evaluated modulo 2^OUT_W.
// Combinational, zero latency; no flow control.
module tiny_exec_dot4 #(
    parameter int W     = 4,
    parameter int OUT_W = 2 * W + 2
) (
    input  logic [3:0][W-1:0]   a,
    input  logic [3:0][W-1:0]   b,
    output logic [OUT_W-1:0]    dot
);

    logic signed [OUT_W-1:0] ae, be, p;

    // Low OUT_W bits of the sum depend only on the low OUT_W bits of each term.
    always_comb begin
        dot = '0;
        ae  = '0;
        be  = '0;
        p   = '0;
        for (int k = 0; k < 4; k++) begin
            ae  = OUT_W'(signed'(a[k]));
            be  = OUT_W'(signed'(b[k]));
            p   = ae * be;
            dot = dot + p;
        end
    end

endmodule

// File: rtl/tiny_exec_unit.sv
// Execution datapath: comb ALU + flags, 8-entry register file, 4x4 MMA engine (PARITY_FLAG_EN enables parity).
// ALU/RF reads zero latency, MMA 16 element cycles then tc_done; no backpressure, tc_write_enable_in restarts.
module tiny_exec_unit #(
    parameter int DATA_W = tiny_exec_pkg::DATA_W,
    parameter int NREGS  = tiny_exec_pkg::NREGS,
    parameter int DIM    = tiny_exec_pkg::DIM
) (
    input  logic                             clock_in,
    input  logic                             reset_in,
    input  logic [7:0]                       opcode_in,
    input  logic [DATA_W-1:0]                alu_input1,
    input  logic [DATA_W-1:0]                alu_input2,
    output logic [DATA_W-1:0]                alu_output,
    output logic                             overflow_flag,
    output logic                             carry_flag,
    output logic                             zero_flag,
    output logic                             sign_flag,
    output logic                             parity_flag,
    input  logic                             rf_write_enable_in,
    input  logic [2:0]                       rf_write_addr_in,
    input  logic [DATA_W-1:0]                rf_write_data_in,
    input  logic [2:0]                       rf_read_addr1_in,
    input  logic [2:0]                       rf_read_addr2_in,
    output logic [DATA_W-1:0]                rf_read_data1_out,
    output logic [DATA_W-1:0]                rf_read_data2_out,
    input  logic                             tc_write_enable_in,
    input  logic [DIM*DIM-1:0][DATA_W-1:0]   tc_input1,
    input  logic [DIM*DIM-1:0][DATA_W-1:0]   tc_input2,
    output logic [DIM*DIM-1:0][DATA_W-1:0]   tc_output,
    output logic                             tc_done
);

    import tiny_exec_pkg::*;

    localparam int MSB = DATA_W - 1;

    logic [DATA_W:0]            add_u, sub_u;
    logic signed [2*DATA_W-1:0] mul_a, mul_b, mul_p;
    logic                       mul_ovf;
    logic [DATA_W-1:0]          res;
    logic                       of, cf;

    always_comb begin
        add_u   = {1'b0, alu_input1} + {1'b0, alu_input2};
        sub_u   = {1'b0, alu_input1} - {1'b0, alu_input2};
        mul_a   = (2*DATA_W)'(signed'(alu_input1));
        mul_b   = (2*DATA_W)'(signed'(alu_input2));
        mul_p   = mul_a * mul_b;
        mul_ovf = mul_p != {{DATA_W{mul_p[MSB]}}, mul_p[DATA_W-1:0]};
        res     = '0;
        of      = 1'b0;
        cf      = 1'b0;
        case (opcode_in)
            ADD: begin
                res = add_u[DATA_W-1:0];
                cf  = add_u[DATA_W];
                of  = (alu_input1[MSB] == alu_input2[MSB]) && (res[MSB] != alu_input1[MSB]);
            end
            ADD_IMM:  res = add_u[DATA_W-1:0];
            SUB: begin
                res = sub_u[DATA_W-1:0];
                cf  = sub_u[DATA_W];
                of  = (alu_input1[MSB] != alu_input2[MSB]) && (res[MSB] != alu_input1[MSB]);
            end
            SUB_IMM:  res = sub_u[DATA_W-1:0];
            MUL: begin
                res = mul_p[DATA_W-1:0];
                cf  = mul_ovf;
                of  = mul_ovf;
            end
            EQL:      res = {{(DATA_W-1){1'b0}}, alu_input1 == alu_input2};
            GRT:      res = {{(DATA_W-1){1'b0}}, $signed(alu_input1) > $signed(alu_input2)};
            MOVE_CPU: res = alu_input1;
            RESET:    res = '0;
            default:  res = '0;
        endcase
    end

    assign alu_output    = res;
    assign overflow_flag = of;
    assign carry_flag    = cf;
    assign zero_flag     = (res == '0);
    assign sign_flag     = res[MSB];
`ifdef PARITY_FLAG_EN
    assign parity_flag   = ^res;
`else
    assign parity_flag   = 1'b0;
`endif

    logic [DATA_W-1:0] regs [NREGS];

    always_ff @(posedge clock_in) begin
        if (reset_in) begin
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
        end else if (rf_write_enable_in) begin
            regs[rf_write_addr_in] <= rf_write_data_in;
        end
    end

    assign rf_read_data1_out = regs[rf_read_addr1_in];
    assign rf_read_data2_out = regs[rf_read_addr2_in];

    mma_state_t           state;
    logic [3:0]           idx;
    logic [1:0]           row, col;
    logic [3:0][DATA_W-1:0] a_row, b_col;
    logic [DATA_W-1:0]    elem;

    assign row = idx[3:2];
    assign col = idx[1:0];

    always_comb begin
        for (int k = 0; k < 4; k++) begin
            a_row[k] = tc_input1[{row, 2'(k)}];
            b_col[k] = tc_input2[{2'(k), col}];
        end
    end

    tiny_exec_dot4 #(.W(DATA_W), .OUT_W(DATA_W)) u_dot4 (
        .a   (a_row),
        .b   (b_col),
        .dot (elem)
    );

    always_ff @(posedge clock_in) begin
        if (reset_in) begin
            state     <= ST_COMPUTE;
            idx       <= '0;
            tc_done   <= 1'b0;
            tc_output <= '0;
        end else if (tc_write_enable_in) begin
            state   <= ST_COMPUTE;
            idx     <= '0;
            tc_done <= 1'b0;
        end else begin
            case (state)
                ST_COMPUTE: begin
                    tc_output[idx] <= elem;
                    idx            <= idx + 4'd1;
                    if (idx == 4'(DIM*DIM-1)) begin
                        state   <= ST_DONE;
                        tc_done <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state   <= ST_HOLD;
                    tc_done <= 1'b0;
                end
                default: begin
                    state   <= ST_HOLD;
                    tc_done <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tiny_exec_unit.sv
// Randomized self-checking bench for tiny_exec_unit against an integer-arithmetic reference model.
// Inputs change after the falling edge; outputs are sampled on the falling edge.
module tb_tiny_exec_unit;

    logic              clock_in = 1'b0;
    logic              reset_in;
    logic [7:0]        opcode_in;
    logic [3:0]        alu_input1, alu_input2, alu_output;
    logic              overflow_flag, carry_flag, zero_flag, sign_flag, parity_flag;
    logic              rf_write_enable_in;
    logic [2:0]        rf_write_addr_in, rf_read_addr1_in, rf_read_addr2_in;
    logic [3:0]        rf_write_data_in, rf_read_data1_out, rf_read_data2_out;
    logic              tc_write_enable_in;
    logic [15:0][3:0]  tc_input1, tc_input2, tc_output;
    logic              tc_done;

    tiny_exec_unit dut (
        .clock_in           (clock_in),
        .reset_in           (reset_in),
        .opcode_in          (opcode_in),
        .alu_input1         (alu_input1),
        .alu_input2         (alu_input2),
        .alu_output         (alu_output),
        .overflow_flag      (overflow_flag),
        .carry_flag         (carry_flag),
        .zero_flag          (zero_flag),
        .sign_flag          (sign_flag),
        .parity_flag        (parity_flag),
        .rf_write_enable_in (rf_write_enable_in),
        .rf_write_addr_in   (rf_write_addr_in),
        .rf_write_data_in   (rf_write_data_in),
        .rf_read_addr1_in   (rf_read_addr1_in),
        .rf_read_addr2_in   (rf_read_addr2_in),
        .rf_read_data1_out  (rf_read_data1_out),
        .rf_read_data2_out  (rf_read_data2_out),
        .tc_write_enable_in (tc_write_enable_in),
        .tc_input1          (tc_input1),
        .tc_input2          (tc_input2),
        .tc_output          (tc_output),
        .tc_done            (tc_done)
    );

    always #5 clock_in = ~clock_in;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    int ma [16];
    int mb [16];
    int rf_m [8];
    int c_m [16];
    int mma_cnt;
    bit mma_idle;
    bit done_m;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    function automatic int wrap4(input int v);
        int r;
        r = v & 15;
        if (r > 7) r -= 16;
        return r;
    endfunction

    // Returns {result[3:0], overflow, carry, zero, sign, parity}.
    function automatic logic [8:0] alu_ref(input int op, input int a, input int b);
        int r;
        int ua;
        int ub;
        bit ov;
        bit cy;
        logic [3:0] res;
        bit par;
        ua = a & 15;
        ub = b & 15;
        ov = 0;
        cy = 0;
        case (op)
            'h00: begin r = a + b; ov = (r > 7) || (r < -8); cy = (ua + ub) > 15; end
            'h09: r = a + b;
            'h01: begin r = a - b; ov = (r > 7) || (r < -8); cy = ua < ub; end
            'h0A: r = a - b;
            'h02: begin r = a * b; ov = (r > 7) || (r < -8); cy = ov; end
            'h03: r = (a == b) ? 1 : 0;
            'h04: r = (a > b) ? 1 : 0;
            'h0B: r = a;
            default: r = 0;
        endcase
        res = 4'(r & 15);
`ifdef PARITY_FLAG_EN
        par = ^res;
`else
        par = 0;
`endif
        return {res, ov, cy, (res == 4'd0), res[3], par};
    endfunction

    task automatic run_alu(input string tag, input int op, input int a, input int b);
        logic [3:0] av;
        logic [3:0] bv;
        av = 4'(a);
        bv = 4'(b);
        opcode_in  = 8'(op);
        alu_input1 = av;
        alu_input2 = bv;
        #1;
        check(tag, {alu_output, overflow_flag, carry_flag, zero_flag, sign_flag, parity_flag},
              alu_ref(op, a, b));
    endtask

    function automatic int mma_elem(input int e);
        int s;
        s = 0;
        for (int k = 0; k < 4; k++) s += ma[(e / 4) * 4 + k] * mb[k * 4 + (e % 4)];
        return wrap4(s);
    endfunction

    function automatic logic [63:0] pack_c();
        logic [63:0] r;
        for (int i = 0; i < 16; i++) r[i*4 +: 4] = 4'(c_m[i]);
        return r;
    endfunction

    task automatic apply_mats();
        for (int i = 0; i < 16; i++) begin
            tc_input1[i] = 4'(ma[i]);
            tc_input2[i] = 4'(mb[i]);
        end
    endtask

    task automatic rand_mats();
        for (int i = 0; i < 16; i++) begin
            ma[i] = wrap4(int'($urandom_range(0, 15)));
            mb[i] = wrap4(int'($urandom_range(0, 15)));
        end
        apply_mats();
    endtask

    task automatic rand_rf();
        rf_write_enable_in = 1'($urandom_range(0, 1));
        rf_write_addr_in   = 3'($urandom_range(0, 7));
        rf_write_data_in   = 4'($urandom_range(0, 15));
        rf_read_addr1_in   = 3'($urandom_range(0, 7));
        rf_read_addr2_in   = 3'($urandom_range(0, 7));
    endtask

    // One clock: update the model with the inputs present at the edge, then compare.
    task automatic tick();
        @(posedge clock_in);
        if (reset_in) begin
            for (int i = 0; i < 8; i++) rf_m[i] = 0;
            for (int i = 0; i < 16; i++) c_m[i] = 0;
            mma_cnt  = 0;
            mma_idle = 0;
            done_m   = 0;
        end else begin
            if (rf_write_enable_in) rf_m[rf_write_addr_in] = int'(rf_write_data_in);
            done_m = 0;
            if (tc_write_enable_in) begin
                mma_cnt  = 0;
                mma_idle = 0;
            end else if (!mma_idle) begin
                c_m[mma_cnt] = mma_elem(mma_cnt);
                mma_cnt++;
                if (mma_cnt == 16) begin
                    done_m   = 1;
                    mma_idle = 1;
                end
            end
        end
        @(negedge clock_in);
        check("tc_done", tc_done, done_m);
        check("tc_output", tc_output, pack_c());
        check("rf_rd1", rf_read_data1_out, rf_m[rf_read_addr1_in]);
        check("rf_rd2", rf_read_data2_out, rf_m[rf_read_addr2_in]);
    endtask

    int ops [9] = '{'h00, 'h09, 'h01, 'h0A, 'h02, 'h03, 'h04, 'h0B, 'h0D};
    logic [63:0] exp_b;

    initial begin
        reset_in           = 1'b1;
        opcode_in          = '0;
        alu_input1         = '0;
        alu_input2         = '0;
        rf_write_enable_in = 1'b0;
        rf_write_addr_in   = '0;
        rf_write_data_in   = '0;
        rf_read_addr1_in   = 3'd0;
        rf_read_addr2_in   = 3'd7;
        tc_write_enable_in = 1'b0;
        for (int i = 0; i < 16; i++) begin
            ma[i] = 0;
            mb[i] = 0;
        end
        apply_mats();
        @(negedge clock_in);
        tick();
        tick();
        check("reset_tc_output", tc_output, 64'd0);
        check("reset_tc_done", tc_done, 1'b0);
        check("reset_rf", rf_read_data1_out, 4'd0);

        // ALU exercised while reset holds all state still.
        run_alu("add_7_1", 'h00, 7, 1);
        check("add_7_1_out", alu_output, 4'b1000);
        check("add_7_1_ovf", overflow_flag, 1'b1);
        check("add_7_1_sign", sign_flag, 1'b1);
        check("add_7_1_carry", carry_flag, 1'b0);
`ifdef PARITY_FLAG_EN
        check("add_7_1_parity", parity_flag, 1'b1);
`else
        check("add_7_1_parity", parity_flag, 1'b0);
`endif
        run_alu("sub_3_5", 'h01, 3, 5);
        check("sub_3_5_out", alu_output, 4'hE);
        check("sub_3_5_carry", carry_flag, 1'b1);
        check("sub_3_5_ovf", overflow_flag, 1'b0);
        run_alu("eql_4_4", 'h03, 4, 4);
        check("eql_4_4_out", alu_output, 4'd1);
        run_alu("grt_m1_2", 'h04, -1, 2);
        check("grt_m1_2_out", alu_output, 4'd0);
        run_alu("mul_3_3", 'h02, 3, 3);
        check("mul_3_3_out", alu_output, 4'h9);
        check("mul_3_3_ovf", overflow_flag, 1'b1);
        for (int i = 0; i < 150; i++) begin
            int op;
            op = (i % 10 == 9) ? int'($urandom_range(0, 255)) : ops[$urandom_range(0, 8)];
            run_alu("alu_rand", op, wrap4(int'($urandom_range(0, 15))), wrap4(int'($urandom_range(0, 15))));
        end

        // MMA identity run starting straight out of reset, with a register write on the first edge.
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) begin
                ma[i*4+j] = (i == j) ? 1 : 0;
                mb[i*4+j] = wrap4(i + j);
                exp_b[(i*4+j)*4 +: 4] = 4'(i + j);
            end
        apply_mats();
        @(negedge clock_in);
        reset_in           = 1'b0;
        rf_write_enable_in = 1'b1;
        rf_write_addr_in   = 3'd5;
        rf_write_data_in   = 4'd6;
        tick();
        rf_write_enable_in = 1'b0;
        rf_read_addr1_in   = 3'd5;
        #1;
        check("rf_reg5", rf_read_data1_out, 4'd6);
        for (int t = 2; t <= 16; t++) begin
            if (t > 2) rand_rf();
            tick();
            if (t < 16) check("ident_no_early_done", tc_done, 1'b0);
        end
        check("ident_done", tc_done, 1'b1);
        check("ident_result", tc_output, exp_b);
        tick();
        check("ident_done_one_cycle", tc_done, 1'b0);
        tick();

        // Register file clears under reset.
        rf_write_enable_in = 1'b0;
        reset_in           = 1'b1;
        tick();
        rf_read_addr1_in = 3'd5;
        #1;
        check("rf_reset_reg5", rf_read_data1_out, 4'd0);
        reset_in = 1'b0;

        // All-ones matrices: every element is 4.
        for (int i = 0; i < 16; i++) begin
            ma[i] = 1;
            mb[i] = 1;
        end
        apply_mats();
        tc_write_enable_in = 1'b1;
        tick();
        tc_write_enable_in = 1'b0;
        for (int t = 1; t <= 16; t++) begin
            rand_rf();
            tick();
        end
        check("ones_done", tc_done, 1'b1);
        check("ones_result", tc_output, 64'h4444_4444_4444_4444);

        // Abort after eight elements, then a full restart.
        rand_mats();
        tc_write_enable_in = 1'b1;
        tick();
        tc_write_enable_in = 1'b0;
        for (int t = 0; t < 8; t++) tick();
        tc_write_enable_in = 1'b1;
        tick();
        check("abort_no_done", tc_done, 1'b0);
        tc_write_enable_in = 1'b0;
        for (int t = 1; t <= 16; t++) begin
            rand_rf();
            tick();
            if (t < 16) check("abort_wait_no_done", tc_done, 1'b0);
        end
        check("abort_restart_done", tc_done, 1'b1);

        // Random matrices with occasional restarts and operand changes.
        for (int r = 0; r < 4; r++) begin
            rand_mats();
            tc_write_enable_in = 1'b1;
            tick();
            tc_write_enable_in = 1'b0;
            for (int t = 0; t < 24; t++) begin
                rand_rf();
                tc_write_enable_in = ($urandom_range(0, 15) == 0);
                if ($urandom_range(0, 7) == 0) rand_mats();
                tick();
            end
            tc_write_enable_in = 1'b0;
            for (int t = 0; t < 18; t++) tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
